// File: rtl/vec_mem_reader.sv
// vec_mem_reader: walks a contiguous range of 16-lane data-memory words and
// streams each word out lane by lane on a valid/ready interface.
// Fetch takes two cycles (ADDR drives the read, WAIT captures the word).
// STREAM then presents lanes 0..15 and holds every output while the sink
// stalls. DONE pulses once before the engine returns to IDLE.

module vec_mem_reader #(
  parameter int N     = 16,
  parameter int LANES = 16
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic                      start,
  input  logic [N-1:0]              base_addr,
  input  logic [N-1:0]              word_count,
  output logic                      mem_re,
  output logic [N-1:0]              mem_addr,
  input  logic [LANES-1:0][N-1:0]   mem_rdata,
  output logic [N-1:0]              out_data,
  output logic [3:0]                out_lane,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_STREAM,
    S_DONE
  } state_t;

  localparam logic [N-1:0] ONE       = N'(1);
  localparam logic [3:0]   LAST_LANE = 4'd15;

  state_t                   r_state;
  logic [N-1:0]             r_addr;
  logic [N-1:0]             r_remaining;
  logic [3:0]               r_lane;
  logic [LANES-1:0][N-1:0]  r_buf;
  logic                     r_mem_re;
  logic [N-1:0]             r_out_data;
  logic                     r_out_valid;
  logic                     r_out_last;
  logic                     r_busy;
  logic                     r_done;

  logic                     w_fire;
  logic [3:0]               w_lane_next;
  logic [N-1:0]             w_remaining_dec;

  // Handshake and next-value helpers used by the state machine.
  assign w_fire          = r_out_valid & out_ready;
  assign w_lane_next     = r_lane + 4'd1;
  assign w_remaining_dec = r_remaining - ONE;

  // Transfer state machine; every output comes straight from a register.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_lane      <= '0;
      // NOTE: the lane buffer is reset along with the control state so that no
      // stale word from an aborted transfer remains visible after reset.
      r_buf       <= '0;
      r_mem_re    <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // register values from before this edge, whatever the statement order.
      r_mem_re <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr      <= base_addr;
            r_remaining <= word_count;
            r_busy      <= 1'b1;
            if (word_count != '0) begin
              r_state  <= S_ADDR;
              r_mem_re <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_buf       <= mem_rdata;
          r_lane      <= '0;
          r_out_data  <= mem_rdata[0];
          r_out_valid <= 1'b1;
          r_out_last  <= 1'b0;
          r_state     <= S_STREAM;
        end
        S_STREAM: begin
          if (w_fire) begin
            if (r_lane != LAST_LANE) begin
              r_lane     <= w_lane_next;
              r_out_data <= r_buf[w_lane_next];
              r_out_last <= (w_lane_next == LAST_LANE) && (r_remaining == ONE);
            end else begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_addr      <= r_addr + ONE;
              r_remaining <= w_remaining_dec;
              if (w_remaining_dec != '0) begin
                r_state  <= S_ADDR;
                r_mem_re <= 1'b1;
              end else begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
              end
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_re    = r_mem_re;
  assign mem_addr  = r_addr;
  assign out_data  = r_out_data;
  assign out_lane  = r_lane;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_vec_mem_reader.sv
// Testbench for vec_mem_reader: a memory model answers reads one cycle later.
// A scoreboard holds the expected beats and read addresses. They are queued
// when a transfer starts and popped as the DUT reads or hands over a beat.

module tb_vec_mem_reader;

  logic                 CLK = 1'b0;
  logic                 reset;
  logic                 start;
  logic [15:0]          base_addr;
  logic [15:0]          word_count;
  logic                 mem_re;
  logic [15:0]          mem_addr;
  logic [15:0][15:0]    mem_rdata;
  logic [15:0]          out_data;
  logic [3:0]           out_lane;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 busy;
  logic                 done;

  vec_mem_reader #(.N(16), .LANES(16)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .mem_re     (mem_re),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  lane;
    logic        last;
  } beat_t;

  beat_t       sb_q[$];
  logic [15:0] addr_q[$];

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  int s_cyc = 0;
  int mem_re_cnt, mem_re_off, done_cnt, done_off;
  int beat_cnt, last_cnt, first_off, last_off;
  int rdy_mode = 0;
  int stall_left = 0;
  int stalled_lane = -1;

  logic        prev_stall = 1'b0;
  logic [15:0] prev_data;
  logic [3:0]  prev_lane;
  logic        prev_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Memory contents: word 0x0010 holds 0x1000+lane, others a distinct pattern.
  function automatic logic [15:0] lane_val(input logic [15:0] a, input int i);
    logic [3:0] li;
    li = 4'(i);
    if (a == 16'h0010) return 16'h1000 + {12'h000, li};
    return {a[11:0], li} ^ 16'h3C00;
  endfunction

  always @(posedge CLK) cyc++;

  // Memory model: data valid the cycle after mem_re, garbage otherwise.
  always @(posedge CLK) begin
    for (int i = 0; i < 16; i++)
      mem_rdata[i] <= mem_re ? lane_val(mem_addr, i) : 16'hDEAD;
  end

  // Sink: always ready, stall lanes 3-5 for 4 cycles each, or random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        1: begin
          if (out_valid && out_lane >= 4'd3 && out_lane <= 4'd5 &&
              int'(out_lane) != stalled_lane && stall_left == 0) begin
            stalled_lane = int'(out_lane);
            stall_left   = 4;
          end
          if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
        2: out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (!reset) begin
        int off;
        off = cyc - s_cyc + 1;
        if (mem_re) begin
          mem_re_cnt++;
          if (mem_re_cnt == 1) mem_re_off = off;
          check("mem_re_expected", 64'(addr_q.size() != 0), 64'd1);
          if (addr_q.size() != 0) check("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
        end
        if (done) begin
          done_cnt++;
          done_off = off;
        end
        if (prev_stall && out_valid) begin
          check("hold_data", 64'(out_data), 64'(prev_data));
          check("hold_lane", 64'(out_lane), 64'(prev_lane));
          check("hold_last", 64'(out_last), 64'(prev_last));
        end
        if (out_valid && out_ready) begin
          beat_cnt++;
          if (first_off < 0) first_off = off;
          last_off = off;
          if (out_last) last_cnt++;
          check("beat_expected", 64'(sb_q.size() != 0), 64'd1);
          if (sb_q.size() != 0) begin
            beat_t b;
            b = sb_q.pop_front();
            check("out_data", 64'(out_data), 64'(b.data));
            check("out_lane", 64'(out_lane), 64'(b.lane));
            check("out_last", 64'(out_last), 64'(b.last));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_lane  = out_lane;
        prev_last  = out_last;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic clear_stats();
    mem_re_cnt   = 0;
    mem_re_off   = -1;
    done_cnt     = 0;
    done_off     = -1;
    beat_cnt     = 0;
    last_cnt     = 0;
    first_off    = -1;
    last_off     = -1;
    stalled_lane = -1;
  endtask

  // Queue expectations, then pulse start; s_cyc marks the sampling edge.
  task automatic do_start(input logic [15:0] base, input logic [15:0] count);
    logic [15:0] a;
    beat_t       b;
    clear_stats();
    a = base;
    for (int w = 0; w < int'(count); w++) begin
      addr_q.push_back(a);
      for (int i = 0; i < 16; i++) begin
        b.data = lane_val(a, i);
        b.lane = 4'(i);
        b.last = (i == 15) && (w == int'(count) - 1);
        sb_q.push_back(b);
      end
      a = a + 16'd1;
    end
    @(posedge CLK);
    #1;
    start      = 1'b1;
    base_addr  = base;
    word_count = count;
    @(posedge CLK);
    #1;
    start = 1'b0;
    s_cyc = cyc;
  endtask

  // Start pulse that the DUT must ignore because it is busy.
  task automatic pulse_start_ignored(input logic [15:0] base, input logic [15:0] count);
    @(posedge CLK);
    #1;
    start      = 1'b1;
    base_addr  = base;
    word_count = count;
    @(posedge CLK);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge CLK);
      n++;
    end
    #1;
    check("done_timeout", 64'(done_cnt != 0), 64'd1);
    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("addr_drained", 64'(addr_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_mem_re"},    64'(mem_re),    64'd0);
    check({pfx, "_mem_addr"},  64'(mem_addr),  64'd0);
    check({pfx, "_out_data"},  64'(out_data),  64'd0);
    check({pfx, "_out_lane"},  64'(out_lane),  64'd0);
    check({pfx, "_out_valid"}, 64'(out_valid), 64'd0);
    check({pfx, "_out_last"},  64'(out_last),  64'd0);
    check({pfx, "_busy"},      64'(busy),      64'd0);
    check({pfx, "_done"},      64'(done),      64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    clear_stats();
    repeat (3) @(posedge CLK);
    #1;
    check_all_zero("rst");
    reset = 1'b0;
    repeat (2) @(posedge CLK);

    // Single word, always ready: exact cycle timing.
    rdy_mode = 0;
    do_start(16'h0010, 16'd1);
    wait_done(100);
    check("sw_mem_re_cnt", 64'(mem_re_cnt), 64'd1);
    check("sw_mem_re_off", 64'(mem_re_off), 64'd1);
    check("sw_first_off",  64'(first_off),  64'd3);
    check("sw_last_off",   64'(last_off),   64'd18);
    check("sw_done_off",   64'(done_off),   64'd19);
    check("sw_beats",      64'(beat_cnt),   64'd16);
    check("sw_last_cnt",   64'(last_cnt),   64'd1);
    @(posedge CLK);
    #1;
    check("sw_busy_after", 64'(busy), 64'd0);

    // Backpressure on lanes 3-5, 4 cycles each: 12 cycles late.
    rdy_mode = 1;
    do_start(16'h0010, 16'd1);
    wait_done(100);
    check("bp_first_off", 64'(first_off), 64'd3);
    check("bp_done_off",  64'(done_off),  64'd31);
    check("bp_beats",     64'(beat_cnt),  64'd16);
    rdy_mode = 0;
    repeat (2) @(posedge CLK);

    // Two words across the address wrap.
    do_start(16'hFFFF, 16'd2);
    wait_done(200);
    check("wr_mem_re_cnt", 64'(mem_re_cnt), 64'd2);
    check("wr_beats",      64'(beat_cnt),   64'd32);
    check("wr_last_cnt",   64'(last_cnt),   64'd1);
    check("wr_last_off",   64'(last_off),   64'd36);
    check("wr_done_off",   64'(done_off),   64'd37);
    repeat (2) @(posedge CLK);

    // Zero count: DONE right away, no memory read.
    do_start(16'h1234, 16'd0);
    check("zc_done", 64'(done), 64'd1);
    check("zc_busy", 64'(busy), 64'd1);
    check("zc_mem_re", 64'(mem_re), 64'd0);
    @(posedge CLK);
    #1;
    check("zc_done_after", 64'(done), 64'd0);
    check("zc_busy_after", 64'(busy), 64'd0);
    repeat (3) @(posedge CLK);
    check("zc_mem_re_cnt", 64'(mem_re_cnt), 64'd0);
    check("zc_done_cnt",   64'(done_cnt),   64'd1);

    // Three words, random backpressure, start pulses ignored while busy.
    rdy_mode = 2;
    do_start(16'h0100, 16'd3);
    repeat (5) @(posedge CLK);
    pulse_start_ignored(16'h0555, 16'd4);
    repeat (15) @(posedge CLK);
    pulse_start_ignored(16'h0AAA, 16'd0);
    repeat (20) @(posedge CLK);
    pulse_start_ignored(16'h0010, 16'd1);
    wait_done(1000);
    rdy_mode = 0;
    repeat (30) @(posedge CLK);
    #1;
    check("ig_beats",      64'(beat_cnt),   64'd48);
    check("ig_done_cnt",   64'(done_cnt),   64'd1);
    check("ig_mem_re_cnt", 64'(mem_re_cnt), 64'd3);
    check("ig_busy",       64'(busy),       64'd0);

    // Reset during lane 7 of word 0: outputs clear at once, no done.
    do_start(16'h0020, 16'd2);
    begin
      int n = 0;
      while (!(out_valid && out_lane == 4'd7) && n < 100) begin
        @(negedge CLK);
        n++;
      end
      check("mr_reach_lane7", 64'(out_valid && out_lane == 4'd7), 64'd1);
    end
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("mr");
    sb_q.delete();
    addr_q.delete();
    @(posedge CLK);
    #1;
    reset = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    check("mr_done_cnt", 64'(done_cnt),  64'd0);
    check("mr_busy",     64'(busy),      64'd0);
    check("mr_valid",    64'(out_valid), 64'd0);

    // Engine still works after the abort.
    do_start(16'h0010, 16'd1);
    wait_done(100);
    check("pr_beats",    64'(beat_cnt), 64'd16);
    check("pr_done_off", 64'(done_off), 64'd19);

    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vec_mem_reader.md
# vec_mem_reader

Read-side streaming engine for the vector CPU's data memory. After the CPU has written result vectors (16 lanes × N bits per word), this block walks a contiguous address range, fetches each 16-lane word and emits it lane by lane on a valid/ready stream toward display or debug logic. It sits beside the CPU on the data-memory read port and only reads.

## Interface
Parameters:
- N, 16, lane width in bits; also memory address width.
- LANES, 16, lanes per memory word; fixed at 16 in this design.

Ports:
- CLK  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- start  input  1  single-cycle request to begin a transfer; sampled in IDLE only.
- base_addr  input  N  first word address, sampled with start.
- word_count  input  N  number of words to read, sampled with start; 0 is legal.
- mem_re  output  1  read strobe to data memory.
- mem_addr  output  N  word address to data memory.
- mem_rdata  input  [15:0][N-1:0]  word read data, valid the cycle after mem_re.
- out_data  output  N  current lane value.
- out_lane  output  4  lane index of out_data.
- out_valid  output  1  out_data/out_lane/out_last valid.
- out_ready  input  1  downstream accepts when high with out_valid.
- out_last  output  1  high on lane 15 of the final word.
- busy  output  1  high in any state except IDLE.
- done  output  1  one-cycle pulse at end of transfer.

## Operation
- States: IDLE, ADDR, WAIT, STREAM, DONE.
- IDLE: busy=0. On start: latch base_addr into addr register, word_count into remaining counter. remaining≠0 → ADDR; remaining=0 → DONE.
- ADDR: mem_re=1, mem_addr=addr. → WAIT.
- WAIT: capture full mem_rdata into 16-lane buffer at end of cycle; lane counter cleared to 0. → STREAM.
- STREAM: out_valid=1, out_data=buffer[lane], out_lane=lane. On out_valid&&out_ready: lane<15 → lane+1; lane=15 → addr+1 (mod 2^N), remaining−1; if new remaining≠0 → ADDR else → DONE.
- DONE: done=1 for exactly one cycle → IDLE.
- out_last = STREAM && lane=15 && remaining=1.
- start while busy: ignored, no effect on in-flight transfer.
- Outputs must not change while out_valid=1 and out_ready=0 (stall holds data, lane, last).
- Address arithmetic unsigned N-bit; 0xFFFF+1 wraps to 0x0000 (N=16).
- mem_addr drives addr in all states; mem_re high only in ADDR.

## Timing
- Reset (async assert, sync deassert by surrounding logic): state=IDLE; mem_re, out_valid, out_last, busy, done = 0; mem_addr, out_data, out_lane, buffer, counters = 0.
- Reset mid-transfer: immediate return to IDLE, no done pulse, stream aborted mid-word.
- start sampled at edge t → ADDR in cycle t+1 → WAIT t+2 → first lane valid t+3.
- Per word with out_ready=1: 2 fetch cycles + 16 stream cycles = 18 cycles; final word followed by 1 DONE cycle.
- word_count=0: start at t → DONE at t+1 → IDLE at t+2; mem_re never asserted.
- busy rises cycle after start accepted, falls cycle after DONE.

## Test plan
- Reset mid-stream: assert reset during lane 7 of word 0 → all outputs 0 same cycle, state IDLE, no done.
- Single word: memory[0x0010] lanes = 0x1000+i, start base=0x0010 count=1, out_ready=1 → mem_re once at t+1 with addr 0x0010; lanes 0..15 values 0x1000..0x100F in cycles t+3..t+18; out_last only at lane 15; done at t+19.
- Backpressure: same setup, out_ready low for lanes 3–5 for 4 cycles each → out_data/out_lane held stable, sequence unchanged, completion delayed exactly 12 cycles.
- Multi-word + wrap: base=0xFFFF, count=2 → reads at 0xFFFF then 0x0000; 32 lane beats; out_last only on 32nd beat.
- Zero count and ignored start: count=0 → done at t+1, no mem_re; start pulses during a 3-word transfer → no restart, exactly 48 beats, one done.
